// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_bridge
// Purpose  : Bridges a level-held core memory port onto a valid/ready,
//            split-response memory bus with timeout and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_we,
  output logic [3:0]  req_wmask,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [1:0] c_s_idle = 2'd0;
  localparam logic [1:0] c_s_req  = 2'd1;
  localparam logic [1:0] c_s_wait = 2'd2;
  localparam logic [1:0] c_s_resp = 2'd3;

  localparam int unsigned      c_cnt_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [3:0]         r_wmask;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic       w_cnt_done;
  logic       w_tmo;
  logic       w_both;
  logic       w_spur;
  logic [1:0] w_err_code;
  logic       w_unused;

  // Byte offset is dropped: the downstream bus is word addressed.
  assign w_unused = ^mem_addr[1:0];

  assign w_cnt_done = (r_cnt == c_cnt_max);
  assign w_tmo  = w_cnt_done && (((r_state == c_s_req)  && !req_ready) ||
                                 ((r_state == c_s_wait) && !rsp_valid));
  assign w_both = (r_state == c_s_idle) && mem_read && mem_write;
  assign w_spur = rsp_valid && (r_state != c_s_wait);

  always_comb begin
    w_err_code = 2'b00;
    if (w_tmo)       w_err_code = 2'b01;
    else if (w_both) w_err_code = 2'b10;
    else if (w_spur) w_err_code = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_s_idle;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      // Only the first error is recorded; later ones are absorbed.
      if (!r_err && (w_err_code != 2'b00)) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end

      case (r_state)
        c_s_idle: begin
          if (mem_read || mem_write) begin
            r_addr  <= {mem_addr[31:2], 2'b00};
            r_we    <= mem_write;
            r_wmask <= mem_write ? mem_wmask : 4'b0000;
            r_wdata <= mem_wdata;
            r_cnt   <= '0;
            r_state <= c_s_req;
          end
        end
        c_s_req: begin
          if (!w_cnt_done) r_cnt <= r_cnt + 1'b1;
          if (req_ready) begin
            r_state <= c_s_wait;
          end else if (w_cnt_done) begin
            r_rdata <= r_we ? 32'h0 : ERR_RDATA;
            r_state <= c_s_resp;
          end
        end
        c_s_wait: begin
          if (!w_cnt_done) r_cnt <= r_cnt + 1'b1;
          if (rsp_valid) begin
            r_rdata <= r_we ? 32'h0 : rsp_rdata;
            r_state <= c_s_resp;
          end else if (w_cnt_done) begin
            r_rdata <= r_we ? 32'h0 : ERR_RDATA;
            r_state <= c_s_resp;
          end
        end
        default: r_state <= c_s_idle;
      endcase
    end
  end

  assign req_valid = (r_state == c_s_req);
  assign mem_resp  = (r_state == c_s_resp);
  assign mem_rdata = r_rdata;
  assign req_addr  = r_addr;
  assign req_we    = r_we;
  assign req_wmask = r_wmask;
  assign req_wdata = r_wdata;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_bridge
// Purpose  : Directed and randomized checks of cpu_mem_bridge against a
//            transaction-level model of the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_bridge;

  localparam int          T    = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic [1:0]  err_code;

  logic        auto_ds = 1'b0;
  logic        d_ready = 1'b0, d_rsp = 1'b0;
  logic [31:0] d_rdata = '0;
  logic        a_ready, a_rsp;
  logic [31:0] a_rdata;

  assign req_ready = auto_ds ? a_ready : d_ready;
  assign rsp_valid = auto_ds ? a_rsp   : d_rsp;
  assign rsp_rdata = auto_ds ? a_rdata : d_rdata;

  cpu_mem_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, its age, and whether
  // it has been handed downstream / answered.
  logic        m_busy, m_hs, m_resp, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;
  logic [1:0]  m_code;
  int          m_age;

  task automatic m_reset();
    m_busy = 0; m_hs = 0; m_resp = 0; m_we = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_wmask = 0; m_code = 0; m_age = 0;
  endtask

  initial begin
    logic tmo, both, spur;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        tmo = 0; both = 0; spur = 0;
        if (m_resp) begin
          spur = rsp_valid;
          m_resp = 0;
          m_busy = 0;
        end else if (m_busy) begin
          if (!m_hs) begin
            spur = rsp_valid;
            if (req_ready) m_hs = 1;
            else if (m_age == T - 1) tmo = 1;
          end else if (rsp_valid) begin
            m_rdata = m_we ? 32'h0 : rsp_rdata;
            m_resp  = 1;
          end else if (m_age == T - 1) begin
            tmo = 1;
          end
          if (tmo) begin
            m_rdata = m_we ? 32'h0 : ERRD;
            m_resp  = 1;
          end
          if (m_age < T - 1) m_age++;
        end else begin
          spur = rsp_valid;
          if (mem_read || mem_write) begin
            m_busy  = 1; m_hs = 0; m_age = 0;
            m_addr  = mem_addr & 32'hFFFF_FFFC;
            m_we    = mem_write;
            m_wmask = mem_write ? mem_wmask : 4'h0;
            m_wdata = mem_wdata;
            both    = mem_read && mem_write;
          end
        end
        if (!m_err && (tmo || both || spur)) begin
          m_err  = 1;
          m_code = tmo ? 2'd1 : (both ? 2'd2 : 2'd3);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        chk("mem_resp",  32'(mem_resp),  32'(m_resp));
        chk("mem_rdata", mem_rdata,      m_rdata);
        chk("req_valid", 32'(req_valid), 32'(m_busy && !m_hs && !m_resp));
        chk("req_addr",  req_addr,       m_addr);
        chk("req_we",    32'(req_we),    32'(m_we));
        chk("req_wmask", 32'(req_wmask), 32'(m_wmask));
        chk("req_wdata", req_wdata,      m_wdata);
        chk("err",       32'(err),       32'(m_err));
        chk("err_code",  32'(err_code),  32'(m_code));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) hs_cnt++;
    end
  end

  // Well-behaved random memory: bounded stall, one response per handshake.
  initial begin
    logic hs, waiting;
    int   dly, stall;
    a_ready = 0; a_rsp = 0; a_rdata = 0; waiting = 0; dly = 0; stall = 0; hs = 0;
    forever begin
      @(negedge clk);
      hs = auto_ds && rst_n && req_valid && a_ready;
      @(posedge clk);
      #1;
      a_rsp = 0;
      if (!auto_ds) begin
        waiting = 0; a_ready = 0; stall = 0;
      end else begin
        if (hs) begin
          waiting = 1;
          dly = $urandom_range(0, 4);
        end
        if (waiting) begin
          if (dly == 0) begin
            a_rsp = 1; a_rdata = $urandom; waiting = 0;
          end else begin
            dly--;
          end
        end
        if (!req_valid) stall = 0;
        else stall++;
        a_ready = (stall >= 4) || ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d);
    tick();
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wmask = m; mem_wdata = d;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mem_resp) break;
    end
    chk("txn_done", 32'(mem_resp), 32'd1);
  endtask

  task automatic idle(input int n);
    tick();
    mem_read = 0; mem_write = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 0;
    mem_read = 0; mem_write = 0; d_ready = 0; d_rsp = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, hs0, rw;
    #1 rst_n = 0;
    #1;
    chk("rst_mem_resp",  32'(mem_resp),  32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_mem_rdata", mem_rdata,      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // Read with minimum latency.
    hs0 = hs_cnt;
    tick();
    mem_read = 1; mem_addr = 32'h4000_0006; d_ready = 1;
    tick();
    chk("t1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_req_addr",  req_addr,       32'h4000_0004);
    chk("t1_req_we",    32'(req_we),    32'd0);
    tick();
    chk("t1_valid_drop", 32'(req_valid), 32'd0);
    d_ready = 0; d_rsp = 1; d_rdata = 32'h1122_3344;
    tick();
    d_rsp = 0;
    chk("t1_resp",  32'(mem_resp), 32'd1);
    chk("t1_rdata", mem_rdata,     32'h1122_3344);
    mem_read = 0;
    tick();
    chk("t1_resp_pulse", 32'(mem_resp), 32'd0);
    chk("t1_hs", 32'(hs_cnt - hs0), 32'd1);

    // Store stalled by a slow bus.
    hs0 = hs_cnt;
    tick();
    mem_write = 1; mem_addr = 32'h0000_1002; mem_wmask = 4'b0100; mem_wdata = 32'h00AB_0000;
    repeat (5) begin
      tick();
      chk("t2_valid", 32'(req_valid), 32'd1);
      chk("t2_addr",  req_addr,       32'h0000_1000);
      chk("t2_we",    32'(req_we),    32'd1);
      chk("t2_wmask", 32'(req_wmask), 32'h4);
      chk("t2_wdata", req_wdata,      32'h00AB_0000);
    end
    d_ready = 1;
    tick();
    d_ready = 0; d_rsp = 1; d_rdata = 32'h5555_AAAA;
    chk("t2_valid_drop", 32'(req_valid), 32'd0);
    tick();
    d_rsp = 0;
    chk("t2_resp",  32'(mem_resp), 32'd1);
    chk("t2_rdata", mem_rdata,     32'd0);
    mem_write = 0;
    tick();
    chk("t2_resp_pulse", 32'(mem_resp), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_hs", 32'(hs_cnt - hs0), 32'd1);

    // Back-to-back store then fetch.
    auto_ds = 1;
    hs0 = hs_cnt;
    txn(1'b0, 1'b1, 32'h0000_2000, 4'b1111, 32'hA5A5_0F0F);
    txn(1'b1, 1'b0, 32'h0000_2004, 4'b0000, 32'h0);
    idle(3);
    chk("t3_hs", 32'(hs_cnt - hs0), 32'd2);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      rw = $urandom_range(0, 1);
      txn(rw == 0, rw == 1, $urandom, (rw == 1) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(2);
    chk("rand_err", 32'(err), 32'd0);
    auto_ds = 0;

    // Hung read times out.
    tick();
    mem_read = 1; mem_addr = 32'h0000_3000; d_ready = 1;
    tick();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 1) d_ready = 0;
      if (mem_resp) begin
        n = i;
        break;
      end
    end
    chk("t4_latency", 32'(n), 32'(T));
    chk("t4_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_code", 32'(err_code), 32'd1);
    mem_read = 0;
    tick();
    tick();
    d_rsp = 1;
    tick();
    d_rsp = 0;
    chk("t4_late_resp", 32'(mem_resp), 32'd0);
    tick();
    chk("t4_code_kept", 32'(err_code), 32'd1);

    // Spurious response while idle.
    do_reset();
    tick();
    d_rsp = 1; d_rdata = 32'h0BAD_0BAD;
    tick();
    d_rsp = 0;
    tick();
    chk("t5_resp", 32'(mem_resp), 32'd0);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_code", 32'(err_code), 32'd3);

    // Reset while a read is outstanding.
    do_reset();
    auto_ds = 1;
    txn(1'b1, 1'b0, 32'h0000_5008, 4'h0, 32'h0);
    idle(1);
    auto_ds = 0;
    tick();
    mem_read = 1; mem_addr = 32'h0000_6000; d_ready = 1;
    tick();
    tick();
    d_ready = 0;
    chk("t6_in_wait", 32'(req_valid), 32'd0);
    #2 rst_n = 0;
    mem_read = 0;
    #1;
    chk("t6_rst_valid", 32'(req_valid), 32'd0);
    chk("t6_rst_resp",  32'(mem_resp),  32'd0);
    chk("t6_rst_rdata", mem_rdata,      32'd0);
    chk("t6_rst_addr",  req_addr,       32'd0);
    chk("t6_rst_err",   32'(err),       32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    d_rsp = 1; d_rdata = 32'h7777_7777;
    tick();
    d_rsp = 0;
    tick();
    chk("t6_resp", 32'(mem_resp), 32'd0);
    chk("t6_code", 32'(err_code), 32'd3);

    // Read and write raised together.
    do_reset();
    auto_ds = 1;
    tick();
    mem_read = 1; mem_write = 1; mem_addr = 32'h0000_7001; mem_wmask = 4'hF; mem_wdata = 32'h1234_5678;
    tick();
    chk("t7_we", 32'(req_we), 32'd1);
    chk("t7_wmask", 32'(req_wmask), 32'hF);
    chk("t7_code", 32'(err_code), 32'd2);
    for (int i = 0; i < 50; i++) begin
      if (mem_resp) break;
      tick();
    end
    chk("t7_resp", 32'(mem_resp), 32'd1);
    chk("t7_rdata", mem_rdata, 32'd0);
    idle(2);
    auto_ds = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
